// File: rtl/hsid_mse_sched_pkg.sv
// Shared widths, scheduler state encoding and element-count helper for the hsid_mse sequencer.
package hsid_mse_sched_pkg;

  localparam int HSID_WORD_WIDTH        = 32;
  localparam int HSID_HSP_BANDS_WIDTH   = 12;
  localparam int HSID_HSP_LIBRARY_WIDTH = 10;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } hsid_sched_state_t;

  // Two bands per word, so a spectrum occupies ceil(bands/2) words.
  function automatic logic [HSID_HSP_BANDS_WIDTH-1:0] num_elems(
      input logic [HSID_HSP_BANDS_WIDTH-1:0] bands);
    logic [HSID_HSP_BANDS_WIDTH:0] sum;
    sum = {1'b0, bands} + (HSID_HSP_BANDS_WIDTH+1)'(1);
    return sum[HSID_HSP_BANDS_WIDTH:1];
  endfunction

endpackage

// File: rtl/hsid_mse_sched_if.sv
// Word-memory read port and hsid_mse element/result port of the scheduler.
interface hsid_mse_sched_if #(
  parameter int WORD_WIDTH        = 32,
  parameter int HSP_BANDS_WIDTH   = 12,
  parameter int HSP_LIBRARY_WIDTH = 10,
  parameter int ADDR_WIDTH        = 16
);
  logic                         rd_req;
  logic                         rd_gnt;
  logic [ADDR_WIDTH-1:0]        px_addr;
  logic [ADDR_WIDTH-1:0]        lib_addr;
  logic [WORD_WIDTH-1:0]        px_data;
  logic [WORD_WIDTH-1:0]        lib_data;
  logic                         mse_clear;
  logic                         element_start;
  logic                         element_last;
  logic                         element_valid;
  logic [WORD_WIDTH-1:0]        element_a;
  logic [WORD_WIDTH-1:0]        element_b;
  logic [HSP_LIBRARY_WIDTH-1:0] vctr_ref;
  logic [HSP_BANDS_WIDTH-1:0]   mse_bands;
  logic [WORD_WIDTH-1:0]        mse_value;
  logic [HSP_LIBRARY_WIDTH-1:0] mse_ref;
  logic                         mse_valid;
  logic                         mse_of;

  modport master (
    output rd_req, px_addr, lib_addr, mse_clear, element_start, element_last,
           element_valid, element_a, element_b, vctr_ref, mse_bands,
    input  rd_gnt, px_data, lib_data, mse_value, mse_ref, mse_valid, mse_of
  );

  modport slave (
    input  rd_req, px_addr, lib_addr, mse_clear, element_start, element_last,
           element_valid, element_a, element_b, vctr_ref, mse_bands,
    output rd_gnt, px_data, lib_data, mse_value, mse_ref, mse_valid, mse_of
  );
endinterface

// File: rtl/hsid_mse_sched_min.sv
// Best-match tracker: keeps the smallest non-overflowed MSE and its reference; ties keep the earlier one.
module hsid_mse_min #(
  parameter int WORD_WIDTH        = 32,
  parameter int HSP_LIBRARY_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init,
  input  logic                         upd,
  input  logic [WORD_WIDTH-1:0]        mse_value,
  input  logic [HSP_LIBRARY_WIDTH-1:0] mse_ref,
  input  logic                         mse_of,
  output logic [WORD_WIDTH-1:0]        min_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] min_ref,
  output logic                         of_seen
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_value <= '1;
      min_ref   <= '0;
      of_seen   <= 1'b0;
    end else if (init) begin
      min_value <= '1;
      min_ref   <= '0;
      of_seen   <= 1'b0;
    end else if (upd) begin
      if (mse_of) begin
        of_seen <= 1'b1;
      end else if (mse_value < min_value) begin
        min_value <= mse_value;
        min_ref   <= mse_ref;
      end
    end
  end

endmodule

// File: rtl/hsid_mse_sched.sv
// Streams one pixel spectrum against each library spectrum into hsid_mse and keeps the best match.
module hsid_mse_sched
  import hsid_mse_sched_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
  parameter int ADDR_WIDTH        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [HSP_BANDS_WIDTH-1:0]   hsi_bands,
  input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
  output logic                         busy,
  output logic                         done,
  output logic [WORD_WIDTH-1:0]        min_mse_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] min_mse_ref,
  output logic                         of_seen,
  hsid_mse_sched_if.master             bus
);

  hsid_sched_state_t state_q, state_d;

  logic [HSP_BANDS_WIDTH-1:0]   bands_q;
  logic [HSP_BANDS_WIDTH-1:0]   elems_q;
  logic [HSP_LIBRARY_WIDTH-1:0] lib_q;
  logic [HSP_BANDS_WIDTH-1:0]   k_q;
  logic [HSP_LIBRARY_WIDTH-1:0] v_q;
  logic [HSP_LIBRARY_WIDTH-1:0] rcv_q;
  logic [HSP_LIBRARY_WIDTH-1:0] rcv_d;
  logic [ADDR_WIDTH-1:0]        lib_addr_q;
  logic                         elem_vld_q, elem_start_q, elem_last_q;
  logic [HSP_LIBRARY_WIDTH-1:0] vref_q;

  logic grant, last_word, last_vec, collect, res_upd;

  assign grant     = (state_q == STREAM) && bus.rd_gnt;
  assign last_word = (k_q == elems_q - HSP_BANDS_WIDTH'(1));
  assign last_vec  = (v_q == lib_q - HSP_LIBRARY_WIDTH'(1));
  assign collect   = (state_q == STREAM) || (state_q == DRAIN);
  assign res_upd   = collect && bus.mse_valid;
  // Include this cycle's result so done follows the final mse_valid by one cycle.
  assign rcv_d     = rcv_q + HSP_LIBRARY_WIDTH'(res_upd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = (bands_q == '0 || lib_q == '0) ? DONE : STREAM;
      STREAM:  if (grant && last_word && last_vec) state_d = DRAIN;
      DRAIN:   if (rcv_d == lib_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bands_q      <= '0;
      elems_q      <= '0;
      lib_q        <= '0;
      k_q          <= '0;
      v_q          <= '0;
      rcv_q        <= '0;
      lib_addr_q   <= '0;
      elem_vld_q   <= 1'b0;
      elem_start_q <= 1'b0;
      elem_last_q  <= 1'b0;
      vref_q       <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        bands_q <= hsi_bands;
        elems_q <= num_elems(hsi_bands);
        lib_q   <= library_size;
      end
      if (state_q == CLEAR) begin
        k_q        <= '0;
        v_q        <= '0;
        rcv_q      <= '0;
        lib_addr_q <= '0;
      end else begin
        rcv_q <= rcv_d;
      end
      // Library words are contiguous, so lib_addr = v*E + k is a plain running count.
      if (grant) begin
        lib_addr_q <= lib_addr_q + ADDR_WIDTH'(1);
        if (last_word) begin
          k_q <= '0;
          v_q <= v_q + HSP_LIBRARY_WIDTH'(1);
        end else begin
          k_q <= k_q + HSP_BANDS_WIDTH'(1);
        end
        vref_q <= v_q + HSP_LIBRARY_WIDTH'(1);
      end
      elem_vld_q   <= grant;
      elem_start_q <= grant && (k_q == '0);
      elem_last_q  <= grant && last_word;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  assign bus.rd_req        = (state_q == STREAM);
  assign bus.px_addr       = ADDR_WIDTH'(k_q);
  assign bus.lib_addr      = lib_addr_q;
  assign bus.mse_clear     = (state_q == CLEAR);
  assign bus.element_valid = elem_vld_q;
  assign bus.element_start = elem_start_q;
  assign bus.element_last  = elem_last_q;
  assign bus.element_a     = elem_vld_q ? bus.px_data : '0;
  assign bus.element_b     = elem_vld_q ? bus.lib_data : '0;
  assign bus.vctr_ref      = vref_q;
  assign bus.mse_bands     = bands_q;

  hsid_mse_min #(
    .WORD_WIDTH       (WORD_WIDTH),
    .HSP_LIBRARY_WIDTH(HSP_LIBRARY_WIDTH)
  ) u_min (
    .clk      (clk),
    .rst      (rst),
    .init     (state_q == CLEAR),
    .upd      (res_upd),
    .mse_value(bus.mse_value),
    .mse_ref  (bus.mse_ref),
    .mse_of   (bus.mse_of),
    .min_value(min_mse_value),
    .min_ref  (min_mse_ref),
    .of_seen  (of_seen)
  );

endmodule
